// File: rtl/addressing_write_sequencer_pkg.sv
// Shared constants, encodings and write-word packing for the addressing write sequencer.
// The packing helpers build the sequencer-side address and data from a checked request.
package addressing_write_sequencer_pkg;

   localparam int WORD_WIDTH              = 36;
   localparam int D_OPERAND_WIDTH         = 12;
   localparam int THREAD_COUNT            = 8;
   localparam int THREAD_ADDR_WIDTH       = 3;
   localparam int INITIAL_THREAD          = 6;
   localparam int PO_INC_COUNT            = 4;
   localparam int PO_INC_COUNT_ADDR_WIDTH = 2;

   localparam int DEFAULT_OFFSET_WRITE_ADDR_OFFSET     = 1000;
   localparam int PROGRAMMED_OFFSETS_WRITE_ADDR_OFFSET = 1004;
   localparam int INCREMENTS_WRITE_ADDR_OFFSET         = 1008;

   localparam int DEFAULT_OFFSET_WRITE_WORD_OFFSET     = 0;
   localparam int DEFAULT_OFFSET_WRITE_WORD_WIDTH      = 10;
   localparam int PROGRAMMED_OFFSETS_WRITE_WORD_OFFSET = 0;
   localparam int PROGRAMMED_OFFSETS_WRITE_WORD_WIDTH  = 10;
   localparam int INCREMENTS_WRITE_WORD_OFFSET         = 20;
   localparam int INCREMENTS_WRITE_WORD_WIDTH          = 4;

   localparam int STARVE_LIMIT = 15;
   localparam int STARVE_WIDTH = 4;

   typedef enum logic [1:0] {
      KIND_DO  = 2'd0,
      KIND_PO  = 2'd1,
      KIND_INC = 2'd2,
      KIND_BAD = 2'd3
   } cfg_kind_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_ERR   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   function automatic logic [D_OPERAND_WIDTH-1:0] pack_addr(
      input logic [1:0]                         kind,
      input logic [PO_INC_COUNT_ADDR_WIDTH-1:0] index
   );
      logic [D_OPERAND_WIDTH-1:0] a;
      a = '0;
      case (kind)
         KIND_DO:  a = D_OPERAND_WIDTH'(DEFAULT_OFFSET_WRITE_ADDR_OFFSET);
         KIND_PO:  a = D_OPERAND_WIDTH'(PROGRAMMED_OFFSETS_WRITE_ADDR_OFFSET) + D_OPERAND_WIDTH'(index);
         KIND_INC: a = D_OPERAND_WIDTH'(INCREMENTS_WRITE_ADDR_OFFSET) + D_OPERAND_WIDTH'(index);
         default:  a = '0;
      endcase
      return a;
   endfunction

   // Only the kind's field is populated; every other bit of the word is zero.
   function automatic logic [WORD_WIDTH-1:0] pack_data(
      input logic [1:0]            kind,
      input logic [WORD_WIDTH-1:0] value
   );
      logic [WORD_WIDTH-1:0] d;
      d = '0;
      case (kind)
         KIND_DO:
            d[DEFAULT_OFFSET_WRITE_WORD_OFFSET +: DEFAULT_OFFSET_WRITE_WORD_WIDTH] =
               value[DEFAULT_OFFSET_WRITE_WORD_WIDTH-1:0];
         KIND_PO:
            d[PROGRAMMED_OFFSETS_WRITE_WORD_OFFSET +: PROGRAMMED_OFFSETS_WRITE_WORD_WIDTH] =
               value[PROGRAMMED_OFFSETS_WRITE_WORD_WIDTH-1:0];
         KIND_INC:
            d[INCREMENTS_WRITE_WORD_OFFSET +: INCREMENTS_WRITE_WORD_WIDTH] =
               value[INCREMENTS_WRITE_WORD_WIDTH-1:0];
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/addressing_write_sequencer_thread_slot_counter.sv
// Barrel write-stage slot tracker: which thread owns the write slot this cycle.
// Wraps COUNT-1 -> 0 and restarts at INITIAL when reset.
module addressing_thread_slot_counter #(
   parameter int COUNT   = 8,
   parameter int WIDTH   = 3,
   parameter int INITIAL = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   output logic [WIDTH-1:0] thread
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         thread <= WIDTH'(INITIAL);
      end else if (thread == WIDTH'(COUNT - 1)) begin
         thread <= '0;
      end else begin
         thread <= thread + WIDTH'(1);
      end
   end

endmodule

// File: rtl/addressing_write_sequencer.sv
// Injects configuration writes into the Addressing write port during the target thread's
// free ALU write slot, forcing the slot (and annulling the ALU write) after STARVE_LIMIT losses.
module addressing_write_sequencer
   import addressing_write_sequencer_pkg::*;
(
   input  logic                               clock,
   input  logic                               reset_n,
   // cfg handshake: a request transfers on a cycle with cfg_valid && cfg_ready; cfg_ready is
   // high only in IDLE; the master holds the request fields stable while cfg_valid is high.
   input  logic                               cfg_valid,
   output logic                               cfg_ready,
   input  logic [THREAD_ADDR_WIDTH-1:0]       cfg_thread,
   input  logic [1:0]                         cfg_kind,
   input  logic [PO_INC_COUNT_ADDR_WIDTH-1:0] cfg_index,
   input  logic [WORD_WIDTH-1:0]              cfg_value,
   output logic                               cfg_done,
   output logic                               cfg_error,
   input  logic                               ALU_wren_in,
   input  logic [D_OPERAND_WIDTH-1:0]         ALU_write_addr_in,
   input  logic [WORD_WIDTH-1:0]              ALU_write_data_in,
   output logic                               ALU_annul,
   output logic                               write_wren_out,
   output logic [D_OPERAND_WIDTH-1:0]         write_addr_out,
   output logic [WORD_WIDTH-1:0]              write_data_out,
   output logic [THREAD_ADDR_WIDTH-1:0]       current_thread,
   output logic [STARVE_WIDTH-1:0]            starve_count,
   output seq_state_t                         fsm_state
);

   seq_state_t                         state, state_nxt;
   logic [THREAD_ADDR_WIDTH-1:0]       req_thread;
   logic [1:0]                         req_kind;
   logic [PO_INC_COUNT_ADDR_WIDTH-1:0] req_index;
   logic [WORD_WIDTH-1:0]              req_value;
   logic [D_OPERAND_WIDTH-1:0]         req_addr;
   logic [WORD_WIDTH-1:0]              req_data;
   logic [STARVE_WIDTH-1:0]            starve_q;
   logic                               seq_take;
   logic                               annul;
   logic                               starve_inc;
   logic                               req_bad;
   logic [31:0]                        thread_ext;
   logic [31:0]                        index_ext;

   addressing_thread_slot_counter #(
      .COUNT   (THREAD_COUNT),
      .WIDTH   (THREAD_ADDR_WIDTH),
      .INITIAL (INITIAL_THREAD)
   ) u_slot_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .thread  (current_thread)
   );

   // Range checks are done at 32 bits so they stay meaningful if the counts stop being powers of two.
   assign thread_ext = 32'(req_thread);
   assign index_ext  = 32'(req_index);
   assign req_bad    = (req_kind == KIND_BAD)
                     || (thread_ext >= 32'(THREAD_COUNT))
                     || (((req_kind == KIND_PO) || (req_kind == KIND_INC))
                         && (index_ext >= 32'(PO_INC_COUNT)));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         req_thread <= '0;
         req_kind   <= '0;
         req_index  <= '0;
         req_value  <= '0;
         req_addr   <= '0;
         req_data   <= '0;
         starve_q   <= '0;
      end else begin
         state <= state_nxt;
         if (cfg_valid && cfg_ready) begin
            req_thread <= cfg_thread;
            req_kind   <= cfg_kind;
            req_index  <= cfg_index;
            req_value  <= cfg_value;
         end
         if (state == ST_CHECK) begin
            req_addr <= pack_addr(req_kind, req_index);
            req_data <= pack_data(req_kind, req_value);
         end
         if (state == ST_DONE) begin
            starve_q <= '0;
         end else if (starve_inc) begin
            starve_q <= starve_q + STARVE_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      seq_take   = 1'b0;
      annul      = 1'b0;
      starve_inc = 1'b0;
      case (state)
         ST_IDLE:  if (cfg_valid) state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = req_bad ? ST_ERR : ST_WAIT;
         ST_ERR:   state_nxt = ST_IDLE;
         ST_DONE:  state_nxt = ST_IDLE;
         ST_WAIT: begin
            if (current_thread == req_thread) begin
               if (!ALU_wren_in) begin
                  seq_take  = 1'b1;
                  state_nxt = ST_DONE;
               end else if (starve_q == STARVE_WIDTH'(STARVE_LIMIT)) begin
                  // Out of patience: take the slot and cancel the ALU write.
                  seq_take  = 1'b1;
                  annul     = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  starve_inc = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign cfg_ready      = (state == ST_IDLE);
   assign cfg_done       = (state == ST_DONE);
   assign cfg_error      = (state == ST_ERR);
   assign ALU_annul      = annul;
   assign write_wren_out = seq_take | ALU_wren_in;
   assign write_addr_out = seq_take ? req_addr : ALU_write_addr_in;
   assign write_data_out = seq_take ? req_data : ALU_write_data_in;
   assign starve_count   = starve_q;
   assign fsm_state      = state;

endmodule

// File: tb/tb_addressing_write_sequencer.sv
// Directed bench for addressing_write_sequencer: slot timing, packing, rejection, starvation, reset.
module tb_addressing_write_sequencer;
   import addressing_write_sequencer_pkg::*;

   localparam logic [D_OPERAND_WIDTH-1:0] ALU_ADDR = 12'h0AB;
   localparam logic [WORD_WIDTH-1:0]      ALU_DATA = 36'h5_5555_5555;

   logic                               clock;
   logic                               reset_n;
   logic                               cfg_valid;
   logic                               cfg_ready;
   logic [THREAD_ADDR_WIDTH-1:0]       cfg_thread;
   logic [1:0]                         cfg_kind;
   logic [PO_INC_COUNT_ADDR_WIDTH-1:0] cfg_index;
   logic [WORD_WIDTH-1:0]              cfg_value;
   logic                               cfg_done;
   logic                               cfg_error;
   logic                               ALU_wren_in;
   logic [D_OPERAND_WIDTH-1:0]         ALU_write_addr_in;
   logic [WORD_WIDTH-1:0]              ALU_write_data_in;
   logic                               ALU_annul;
   logic                               write_wren_out;
   logic [D_OPERAND_WIDTH-1:0]         write_addr_out;
   logic [WORD_WIDTH-1:0]              write_data_out;
   logic [THREAD_ADDR_WIDTH-1:0]       current_thread;
   logic [STARVE_WIDTH-1:0]            starve_count;
   seq_state_t                         fsm_state;

   int checks = 0;
   int errors = 0;

   // Observation results of the most recent observe() call
   int                         o_issues, o_done, o_err, o_annul, o_pass_bad, o_timeout;
   int                         o_issue_cyc, o_done_cyc, o_slot_idx, o_ready_after;
   logic [THREAD_ADDR_WIDTH-1:0] o_issue_thread;
   logic [D_OPERAND_WIDTH-1:0]   o_issue_addr;
   logic [WORD_WIDTH-1:0]        o_issue_data;
   logic [STARVE_WIDTH-1:0]      o_issue_starve;

   addressing_write_sequencer dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .cfg_valid         (cfg_valid),
      .cfg_ready         (cfg_ready),
      .cfg_thread        (cfg_thread),
      .cfg_kind          (cfg_kind),
      .cfg_index         (cfg_index),
      .cfg_value         (cfg_value),
      .cfg_done          (cfg_done),
      .cfg_error         (cfg_error),
      .ALU_wren_in       (ALU_wren_in),
      .ALU_write_addr_in (ALU_write_addr_in),
      .ALU_write_data_in (ALU_write_data_in),
      .ALU_annul         (ALU_annul),
      .write_wren_out    (write_wren_out),
      .write_addr_out    (write_addr_out),
      .write_data_out    (write_data_out),
      .current_thread    (current_thread),
      .starve_count      (starve_count),
      .fsm_state         (fsm_state)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request; caller is between a negedge and the next posedge.
   task automatic send(input logic [2:0] thr, input logic [1:0] kind,
                       input logic [1:0] idx, input logic [WORD_WIDTH-1:0] val);
      check("ready_before_send", 64'(cfg_ready), 64'd1);
      cfg_thread = thr;
      cfg_kind   = kind;
      cfg_index  = idx;
      cfg_value  = val;
      cfg_valid  = 1'b1;
      @(posedge clock);
      #1;
      cfg_valid  = 1'b0;
   endtask

   // Watch the write port cycle by cycle. mode 0: no ALU traffic; mode 1: ALU writes in the
   // first three target slots; mode 2: ALU writes every cycle. Cycle 0 is the CHECK cycle.
   task automatic observe(input int max_cyc, input int mode, input logic [2:0] tgt, input int tail);
      int left;
      int tslots;
      left = -1;
      tslots = 0;
      o_issues = 0; o_done = 0; o_err = 0; o_annul = 0; o_pass_bad = 0; o_timeout = 0;
      o_issue_cyc = -1; o_done_cyc = -1; o_slot_idx = -1; o_ready_after = 0;
      o_issue_thread = '0; o_issue_addr = '0; o_issue_data = '0; o_issue_starve = '0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clock);
         case (mode)
            1:       ALU_wren_in = (c >= 1) && (current_thread == tgt) && (tslots < 3);
            2:       ALU_wren_in = 1'b1;
            default: ALU_wren_in = 1'b0;
         endcase
         if ((c >= 1) && (current_thread == tgt) && ALU_wren_in) tslots++;
         #1;
         if (ALU_wren_in && !ALU_annul) begin
            if (!write_wren_out || (write_addr_out !== ALU_ADDR) || (write_data_out !== ALU_DATA))
               o_pass_bad++;
         end else if (write_wren_out) begin
            o_issues++;
            o_issue_cyc    = c;
            o_issue_thread = current_thread;
            o_issue_addr   = write_addr_out;
            o_issue_data   = write_data_out;
            o_issue_starve = starve_count;
            o_slot_idx     = tslots;
         end
         if (ALU_annul) o_annul++;
         if ((o_done_cyc >= 0) && (c == o_done_cyc + 1)) o_ready_after = int'(cfg_ready);
         if (cfg_done) begin
            o_done++;
            if (o_done_cyc < 0) o_done_cyc = c;
         end
         if (cfg_error) o_err++;
         if (left > 0) left--;
         if ((left < 0) && (cfg_done || cfg_error)) left = tail;
         if (left == 0) break;
      end
      o_timeout = ((o_done + o_err) == 0) ? 1 : 0;
   endtask

   initial begin
      reset_n           = 1'b0;
      cfg_valid         = 1'b0;
      cfg_thread        = '0;
      cfg_kind          = '0;
      cfg_index         = '0;
      cfg_value         = '0;
      ALU_wren_in       = 1'b1;
      ALU_write_addr_in = ALU_ADDR;
      ALU_write_data_in = ALU_DATA;

      // Reset state, with ALU traffic passing through
      repeat (3) @(negedge clock);
      #1;
      check("rst_thread", 64'(current_thread), 64'd6);
      check("rst_starve", 64'(starve_count), 64'd0);
      check("rst_done", 64'(cfg_done), 64'd0);
      check("rst_error", 64'(cfg_error), 64'd0);
      check("rst_annul", 64'(ALU_annul), 64'd0);
      check("rst_ready", 64'(cfg_ready), 64'd1);
      check("rst_pass_wren", 64'(write_wren_out), 64'd1);
      check("rst_pass_addr", 64'(write_addr_out), 64'(ALU_ADDR));
      check("rst_pass_data", 64'(write_data_out), 64'(ALU_DATA));
      ALU_wren_in = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("release_thread", 64'(current_thread), 64'd6);

      // DO, thread 2, accepted in slot 6: CHECK at 7, WAIT 0,1, issue at 2
      send(3'd2, KIND_DO, 2'd0, 36'h3FF);
      observe(40, 0, 3'd2, 2);
      check("do_timeout", 64'(o_timeout), 64'd0);
      check("do_issues", 64'(o_issues), 64'd1);
      check("do_thread", 64'(o_issue_thread), 64'd2);
      check("do_latency", 64'(o_issue_cyc), 64'd3);
      check("do_addr", 64'(o_issue_addr), 64'd1000);
      check("do_data", 64'(o_issue_data), 64'h3FF);
      check("do_done_count", 64'(o_done), 64'd1);
      check("do_done_cycle", 64'(o_done_cyc), 64'(o_issue_cyc + 1));
      check("do_ready_after_done", 64'(o_ready_after), 64'd1);
      check("do_annul", 64'(o_annul), 64'd0);
      check("do_error", 64'(o_err), 64'd0);

      // INC, thread 0, index 3, value 0xFA -> only the low nibble at bit 20
      send(3'd0, KIND_INC, 2'd3, 36'hFA);
      observe(40, 0, 3'd0, 2);
      check("inc_timeout", 64'(o_timeout), 64'd0);
      check("inc_issues", 64'(o_issues), 64'd1);
      check("inc_thread", 64'(o_issue_thread), 64'd0);
      check("inc_addr", 64'(o_issue_addr), 64'd1011);
      check("inc_data", 64'(o_issue_data), 64'h00A0_0000);
      check("inc_done_count", 64'(o_done), 64'd1);

      // Illegal kind: rejected, no write
      send(3'd3, KIND_BAD, 2'd3, 36'h123);
      observe(20, 0, 3'd3, 2);
      check("bad_error_count", 64'(o_err), 64'd1);
      check("bad_issues", 64'(o_issues), 64'd0);
      check("bad_done", 64'(o_done), 64'd0);
      #1;
      check("bad_ready_after", 64'(cfg_ready), 64'd1);

      // PO, thread 7, index 1: value truncated to 10 bits
      send(3'd7, KIND_PO, 2'd1, 36'hF_FFFF_F2AB);
      observe(40, 0, 3'd7, 2);
      check("po_timeout", 64'(o_timeout), 64'd0);
      check("po_issues", 64'(o_issues), 64'd1);
      check("po_thread", 64'(o_issue_thread), 64'd7);
      check("po_addr", 64'(o_issue_addr), 64'd1005);
      check("po_data", 64'(o_issue_data), 64'h2AB);
      check("po_error", 64'(o_err), 64'd0);

      // Three lost thread-4 slots, then a free one
      send(3'd4, KIND_DO, 2'd0, 36'h155);
      observe(100, 1, 3'd4, 2);
      check("st3_timeout", 64'(o_timeout), 64'd0);
      check("st3_issues", 64'(o_issues), 64'd1);
      check("st3_thread", 64'(o_issue_thread), 64'd4);
      check("st3_starve_at_issue", 64'(o_issue_starve), 64'd3);
      check("st3_addr", 64'(o_issue_addr), 64'd1000);
      check("st3_data", 64'(o_issue_data), 64'h155);
      check("st3_annul", 64'(o_annul), 64'd0);
      check("st3_passthrough", 64'(o_pass_bad), 64'd0);
      check("st3_starve_cleared", 64'(starve_count), 64'd0);

      // ALU always writing: forced take-over on the 16th thread-1 slot
      send(3'd1, KIND_PO, 2'd2, 36'h2AB);
      observe(200, 2, 3'd1, 2);
      ALU_wren_in = 1'b0;
      check("force_timeout", 64'(o_timeout), 64'd0);
      check("force_issues", 64'(o_issues), 64'd1);
      check("force_slot_index", 64'(o_slot_idx), 64'd16);
      check("force_thread", 64'(o_issue_thread), 64'd1);
      check("force_starve_at_issue", 64'(o_issue_starve), 64'd15);
      check("force_annul_cycles", 64'(o_annul), 64'd1);
      check("force_addr", 64'(o_issue_addr), 64'd1006);
      check("force_data", 64'(o_issue_data), 64'h2AB);
      check("force_passthrough", 64'(o_pass_bad), 64'd0);
      check("force_done_count", 64'(o_done), 64'd1);
      check("force_starve_cleared", 64'(starve_count), 64'd0);

      // Reset while waiting for thread 5: request is dropped
      @(negedge clock);
      #1;
      send(3'd5, KIND_DO, 2'd0, 36'h001);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("midrst_wren", 64'(write_wren_out), 64'd0);
      check("midrst_done", 64'(cfg_done), 64'd0);
      check("midrst_thread", 64'(current_thread), 64'd6);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("midrst_ready", 64'(cfg_ready), 64'd1);
      check("midrst_release_thread", 64'(current_thread), 64'd6);
      check("midrst_starve", 64'(starve_count), 64'd0);
      observe(16, 0, 3'd5, 2);
      check("midrst_no_write", 64'(o_issues), 64'd0);
      check("midrst_no_done", 64'(o_done), 64'd0);
      check("midrst_no_error", 64'(o_err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
